// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the instruction-fetch stage.
//   - bus widths for addresses, words, register indices and jump targets
//   - bit ranges of the raw instruction fields
//   - opcodes whose 16-bit immediate is zero-extended
//   - the bubble word (decoded by ID as NOP) and the fetch FSM states
//   - extend_imm(): immediate extension rule shared by the IF/ID register
package if_stage_pkg;

  localparam int INST_ADDR_BUS  = 32;
  localparam int WORD_BUS       = 32;
  localparam int REG_BUS        = 5;
  localparam int RAW_TARGET_BUS = 26;
  localparam int RAW_OPCODE_BUS = 6;
  localparam int RAW_FN_BUS     = 6;
  localparam int RAW_IMM_BUS    = 16;

  // Field bit ranges inside an instruction word
  localparam int RAW_OPCODE_MSB = 31;
  localparam int RAW_OPCODE_LSB = 26;
  localparam int RAW_RS_MSB     = 25;
  localparam int RAW_RS_LSB     = 21;
  localparam int RAW_RT_MSB     = 20;
  localparam int RAW_RT_LSB     = 16;
  localparam int RAW_RD_MSB     = 15;
  localparam int RAW_RD_LSB     = 11;
  localparam int RAW_SA_MSB     = 10;
  localparam int RAW_SA_LSB     = 6;
  localparam int RAW_FN_MSB     = 5;
  localparam int RAW_FN_LSB     = 0;
  localparam int RAW_IMM_MSB    = 15;
  localparam int RAW_IMM_LSB    = 0;
  localparam int RAW_TARGET_MSB = 25;
  localparam int RAW_TARGET_LSB = 0;

  localparam logic [RAW_OPCODE_BUS-1:0] ID_OPCODE_ANDI = 6'h0c;
  localparam logic [RAW_OPCODE_BUS-1:0] ID_OPCODE_ORI  = 6'h0d;
  localparam logic [RAW_OPCODE_BUS-1:0] ID_OPCODE_XORI = 6'h0e;
  localparam logic [RAW_OPCODE_BUS-1:0] ID_OPCODE_LUI  = 6'h0f;

  localparam logic [WORD_BUS-1:0] BUBBLE_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_STATE_IDLE  = 2'd0,  // out of reset, no request yet
    IF_STATE_FETCH = 2'd1,  // request outstanding
    IF_STATE_HOLD  = 2'd2,  // fetched word parked in the skid register
    IF_STATE_DROP  = 2'd3   // waiting to discard a stale response
  } if_state_e;

  // Logical immediates are zero-extended, everything else sign-extended.
  function automatic logic [WORD_BUS-1:0] extend_imm(
    input logic [RAW_OPCODE_BUS-1:0] opcode,
    input logic [RAW_IMM_BUS-1:0]    imm
  );
    logic zero_ext;
    zero_ext = (opcode == ID_OPCODE_ANDI) || (opcode == ID_OPCODE_ORI) ||
               (opcode == ID_OPCODE_XORI) || (opcode == ID_OPCODE_LUI);
    return zero_ext ? {16'h0000, imm} : {{16{imm[RAW_IMM_BUS-1]}}, imm};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register plus field slicing.
//   clk, rst      : clock, asynchronous active-high reset (clears to bubble)
//   load          : capture word/pc on the next edge
//   bubble        : capture the bubble (all-zero word, pc 0); wins over load
//   word, pc      : instruction word and its address to capture
//   pc_q .. target: decoded fields of the held instruction
// With neither load nor bubble the register holds (ID stall).
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      bubble,
  input  logic [WORD_BUS-1:0]       word,
  input  logic [INST_ADDR_BUS-1:0]  pc,
  output logic [INST_ADDR_BUS-1:0]  pc_q,
  output logic [RAW_OPCODE_BUS-1:0] opcode,
  output logic [REG_BUS-1:0]        rs,
  output logic [REG_BUS-1:0]        rt,
  output logic [REG_BUS-1:0]        rd,
  output logic [REG_BUS-1:0]        sa,
  output logic [RAW_FN_BUS-1:0]     fn,
  output logic [WORD_BUS-1:0]       imm,
  output logic [RAW_TARGET_BUS-1:0] target
);

  logic [WORD_BUS-1:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= BUBBLE_WORD;
      pc_q   <= '0;
    end else if (bubble) begin
      word_q <= BUBBLE_WORD;
      pc_q   <= '0;
    end else if (load) begin
      word_q <= word;
      pc_q   <= pc;
    end
  end

  // The raw word is held and sliced after the register; a bubble word of
  // zero yields all-zero fields including the immediate.
  assign opcode = word_q[RAW_OPCODE_MSB:RAW_OPCODE_LSB];
  assign rs     = word_q[RAW_RS_MSB:RAW_RS_LSB];
  assign rt     = word_q[RAW_RT_MSB:RAW_RT_LSB];
  assign rd     = word_q[RAW_RD_MSB:RAW_RD_LSB];
  assign sa     = word_q[RAW_SA_MSB:RAW_SA_LSB];
  assign fn     = word_q[RAW_FN_MSB:RAW_FN_LSB];
  assign target = word_q[RAW_TARGET_MSB:RAW_TARGET_LSB];
  assign imm    = extend_imm(word_q[RAW_OPCODE_MSB:RAW_OPCODE_LSB],
                             word_q[RAW_IMM_MSB:RAW_IMM_LSB]);

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with PC, fetch FSM and skid register.
//   clk, rst       : clock, asynchronous active-high reset
//   i_stall        : ID stall, IF/ID holds while high
//   i_redirect     : flush + redirect (highest priority, overrides stall)
//   i_redirectPc   : redirect target, low two bits ignored
//   o_imemReq      : fetch request, o_imemAddr : fetch address (= pc)
//   i_imemValid    : response valid, i_imemData : instruction word
//   o_pc .. o_target : decoded fields of the instruction held for ID
//   o_dbgState     : current fetch FSM state, for observation only
//
// Memory handshake: a request is issued while o_imemReq is high with
// o_imemAddr held stable; it completes in any cycle where
// o_imemReq & i_imemValid (including the first request cycle). At most one
// request is outstanding. A response arriving while o_imemReq is low
// (DROP) belongs to an abandoned request and is discarded.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_stall,
  input  logic                      i_redirect,
  input  logic [INST_ADDR_BUS-1:0]  i_redirectPc,
  output logic                      o_imemReq,
  output logic [INST_ADDR_BUS-1:0]  o_imemAddr,
  input  logic                      i_imemValid,
  input  logic [WORD_BUS-1:0]       i_imemData,
  output logic [INST_ADDR_BUS-1:0]  o_pc,
  output logic [RAW_OPCODE_BUS-1:0] o_opcode,
  output logic [REG_BUS-1:0]        o_rs,
  output logic [REG_BUS-1:0]        o_rt,
  output logic [REG_BUS-1:0]        o_rd,
  output logic [REG_BUS-1:0]        o_sa,
  output logic [RAW_FN_BUS-1:0]     o_fn,
  output logic [WORD_BUS-1:0]       o_imm,
  output logic [RAW_TARGET_BUS-1:0] o_target,
  output if_state_e                 o_dbgState
);

  if_state_e                state, state_nxt;
  logic [INST_ADDR_BUS-1:0] pc, pc_nxt;
  logic [WORD_BUS-1:0]      skid_word;
  logic [INST_ADDR_BUS-1:0] skid_pc;
  logic                     skid_load;
  logic                     ifid_load, ifid_bubble;
  logic [WORD_BUS-1:0]      ifid_word;
  logic [INST_ADDR_BUS-1:0] ifid_pc;
  logic                     done;

  assign done = (state == IF_STATE_FETCH) && i_imemValid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IF_STATE_IDLE;
      pc        <= RESET_PC;
      skid_word <= BUBBLE_WORD;
      skid_pc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (skid_load) begin
        skid_word <= i_imemData;
        skid_pc   <= pc;
      end
    end
  end

  // The skid register is valid exactly while in HOLD, so leaving HOLD on a
  // redirect is what invalidates it.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    skid_load   = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_word   = i_imemData;
    ifid_pc     = pc;

    if (i_redirect) begin
      pc_nxt      = i_redirectPc & ~32'h0000_0003;
      ifid_bubble = 1'b1;
      // A request still in flight must have its response swallowed. In DROP
      // a response arriving alongside the redirect is that stale response,
      // so nothing remains in flight and fetching can resume.
      if ((state == IF_STATE_FETCH && !done) ||
          (state == IF_STATE_DROP && !i_imemValid)) begin
        state_nxt = IF_STATE_DROP;
      end else begin
        state_nxt = IF_STATE_FETCH;
      end
    end else begin
      case (state)
        IF_STATE_IDLE: begin
          state_nxt   = IF_STATE_FETCH;
          ifid_bubble = !i_stall;
        end
        IF_STATE_FETCH: begin
          if (done) begin
            pc_nxt = pc + 32'd4;
            if (i_stall) begin
              skid_load = 1'b1;
              state_nxt = IF_STATE_HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end else begin
            ifid_bubble = !i_stall;
          end
        end
        IF_STATE_HOLD: begin
          if (!i_stall) begin
            ifid_load = 1'b1;
            ifid_word = skid_word;
            ifid_pc   = skid_pc;
            state_nxt = IF_STATE_FETCH;
          end
        end
        IF_STATE_DROP: begin
          ifid_bubble = !i_stall;
          if (i_imemValid) begin
            state_nxt = IF_STATE_FETCH;
          end
        end
        default: state_nxt = IF_STATE_IDLE;
      endcase
    end
  end

  assign o_imemReq  = (state == IF_STATE_FETCH);
  assign o_imemAddr = pc;
  assign o_dbgState = state;

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .word   (ifid_word),
    .pc     (ifid_pc),
    .pc_q   (o_pc),
    .opcode (o_opcode),
    .rs     (o_rs),
    .rt     (o_rt),
    .rd     (o_rd),
    .sa     (o_sa),
    .fn     (o_fn),
    .imm    (o_imm),
    .target (o_target)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + randomized bench for if_stage.
// A behavioural instruction memory with programmable latency answers the
// main instance; a second instance with RESET_PC = 32'hFFFF_FFFC runs on
// zero-wait memory to observe PC wrap-around.
module tb_if_stage;
  import if_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        i_stall = 1'b0, i_redirect = 1'b0;
  logic [31:0] i_redirectPc = 32'h0;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemValid = 1'b0;
  logic [31:0] i_imemData = 32'h0;
  logic [31:0] o_pc, o_imm;
  logic [5:0]  o_opcode, o_fn;
  logic [4:0]  o_rs, o_rt, o_rd, o_sa;
  logic [25:0] o_target;
  if_state_e   o_dbgState;

  if_stage u_dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirectPc(i_redirectPc), .o_imemReq(o_imemReq), .o_imemAddr(o_imemAddr),
    .i_imemValid(i_imemValid), .i_imemData(i_imemData), .o_pc(o_pc),
    .o_opcode(o_opcode), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_sa(o_sa),
    .o_fn(o_fn), .o_imm(o_imm), .o_target(o_target), .o_dbgState(o_dbgState)
  );

  // ---------------- wrap-around DUT ----------------
  logic        w_stall = 1'b0, w_redirect = 1'b0;
  logic [31:0] w_redirectPc = 32'h0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid = 1'b0;
  logic [31:0] w_data = 32'h0;
  logic [31:0] w_pc, w_imm;
  logic [5:0]  w_opcode, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_sa;
  logic [25:0] w_target;
  if_state_e   w_state;

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .i_stall(w_stall), .i_redirect(w_redirect),
    .i_redirectPc(w_redirectPc), .o_imemReq(w_req), .o_imemAddr(w_addr),
    .i_imemValid(w_valid), .i_imemData(w_data), .o_pc(w_pc),
    .o_opcode(w_opcode), .o_rs(w_rs), .o_rt(w_rt), .o_rd(w_rd), .o_sa(w_sa),
    .o_fn(w_fn), .o_imm(w_imm), .o_target(w_target), .o_dbgState(w_state)
  );

  // ---------------- reference model state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc = 32'h0;   // address of the next instruction ID must see
  int          lat_cfg = 0;      // memory latency, negative = random 0..3
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;

  logic [121:0] disp;
  logic [31:0]  disp_word;
  assign disp      = {o_pc, o_opcode, o_rs, o_rt, o_rd, o_sa, o_fn, o_imm, o_target};
  assign disp_word = {o_opcode, o_rs, o_rt, o_rd, o_sa, o_fn};

  // Program image: three directed words, hashed nonzero words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3421_1234;
      32'h0000_0004: return 32'h2002_8000;
      32'h0000_0008: return 32'h3002_8000;
      default:       return ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234) | 32'h1;
    endcase
  endfunction

  // Logical-immediate opcodes 12..15 zero-extend, others sign-extend.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int unsigned op, lo;
    op = w >> 26;
    lo = w & 32'h0000_FFFF;
    if (op >= 12 && op <= 15) return lo;
    return (lo >= 32768) ? lo + 32'hFFFF_0000 : lo;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks what ID sees after an edge, given the inputs applied before it.
  task automatic monitor(input logic p_stall, input logic p_redir,
                         input logic [31:0] p_rpc, input logic [121:0] p_disp);
    if (p_redir) begin
      check("redirect_bubble", 128'(disp), 128'(0));
      exp_pc = p_rpc & 32'hFFFF_FFFC;
    end else if (p_stall) begin
      check("stall_hold", 128'(disp), 128'(p_disp));
    end else if (disp_word != 32'h0) begin
      check("seq_pc", 128'(o_pc), 128'(exp_pc));
      exp_pc = o_pc + 32'd4;
    end
    if (disp_word != 32'h0) begin
      check("word", 128'(disp_word), 128'(mem_word(o_pc)));
      check("target", 128'(o_target), 128'(disp_word[25:0]));
      check("imm", 128'(o_imm), 128'(ref_imm(disp_word)));
    end else begin
      check("bubble_fields", 128'({o_pc, o_imm, o_target}), 128'(0));
    end
  endtask

  // Memory responder, evaluated once per cycle away from the clock edge.
  task automatic drive_mem();
    i_imemValid = 1'b0;
    i_imemData  = $urandom;
    if (rst) begin
      mem_busy = 1'b0;
    end else begin
      if (!mem_busy && o_imemReq) begin
        mem_busy = 1'b1;
        mem_addr = o_imemAddr;
        mem_cnt  = (lat_cfg < 0) ? $urandom_range(0, 3) : lat_cfg;
      end else if (mem_busy && o_imemReq) begin
        check("addr_stable", 128'(o_imemAddr), 128'(mem_addr));
      end
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          i_imemValid = 1'b1;
          i_imemData  = mem_word(mem_addr);
          mem_busy    = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
    end
    w_valid = w_req;
    w_data  = 32'h3C01_0000 | (w_addr & 32'hFFFF);
  endtask

  task automatic step();
    logic          p_stall, p_redir;
    logic [31:0]   p_rpc;
    logic [121:0]  p_disp;
    p_stall = i_stall;
    p_redir = i_redirect;
    p_rpc   = i_redirectPc;
    p_disp  = disp;
    @(posedge clk);
    @(negedge clk);
    if (!rst) monitor(p_stall, p_redir, p_rpc, p_disp);
    drive_mem();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    repeat (3) step();
    check("reset_req", 128'(o_imemReq), 128'(1'b0));
    check("reset_addr", 128'(o_imemAddr), 128'(32'h0));
    check("reset_fields", 128'(disp), 128'(0));
    check("reset_state", 128'(o_dbgState), 128'(IF_STATE_IDLE));
    check("wrap_reset_addr", 128'(w_addr), 128'(32'hFFFF_FFFC));

    // Reset release with zero-wait memory
    rst = 1'b0;
    exp_pc = 32'h0;
    check("release_req_low", 128'(o_imemReq), 128'(1'b0));
    step();
    check("first_req", 128'(o_imemReq), 128'(1'b1));
    check("first_addr", 128'(o_imemAddr), 128'(32'h0));
    check("wrap_first_addr", 128'(w_addr), 128'(32'hFFFF_FFFC));
    step();
    check("pc0_opcode", 128'(o_opcode), 128'(6'h0d));
    check("pc0_rs", 128'(o_rs), 128'(5'd1));
    check("pc0_rt", 128'(o_rt), 128'(5'd1));
    check("pc0_imm", 128'(o_imm), 128'(32'h0000_1234));
    check("pc0_pc", 128'(o_pc), 128'(32'h0));
    check("wrap_second_addr", 128'(w_addr), 128'(32'h0));
    check("wrap_held_pc", 128'(w_pc), 128'(32'hFFFF_FFFC));
    step();
    check("addi_imm", 128'(o_imm), 128'(32'hFFFF_8000));
    check("pc8_req_addr", 128'(o_imemAddr), 128'(32'h8));

    // Stall while the PC 8 fetch completes, held for three cycles
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_pc", 128'(o_pc), 128'(32'h4));
      check("hold_req_low", 128'(o_imemReq), 128'(1'b0));
      check("hold_state", 128'(o_dbgState), 128'(IF_STATE_HOLD));
    end
    i_stall = 1'b0;
    step();
    check("skid_pc", 128'(o_pc), 128'(32'h8));
    check("andi_opcode", 128'(o_opcode), 128'(6'h0c));
    check("andi_imm", 128'(o_imm), 128'(32'h0000_8000));
    step();
    check("after_skid_pc", 128'(o_pc), 128'(32'hC));

    // Redirect during a slow fetch
    lat_cfg = 3;
    step();
    check("slow_req", 128'(o_imemReq), 128'(1'b1));
    check("slow_wait", 128'(i_imemValid), 128'(1'b0));
    i_redirect = 1'b1;
    i_redirectPc = 32'h0000_0103;
    step();
    i_redirect = 1'b0;
    check("drop_bubble_pc", 128'(o_pc), 128'(32'h0));
    check("drop_bubble_op", 128'(o_opcode), 128'(6'h0));
    check("drop_req_low", 128'(o_imemReq), 128'(1'b0));
    check("drop_state", 128'(o_dbgState), 128'(IF_STATE_DROP));
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (o_imemReq) found = 1'b1;
      else step();
    end
    check("drop_resume", 128'(found), 128'(1'b1));
    check("redirect_addr", 128'(o_imemAddr), 128'(32'h0000_0100));
    lat_cfg = 0;

    // Redirect together with stall and a completing fetch
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (o_imemReq && i_imemValid) found = 1'b1;
      else step();
    end
    check("completion_seen", 128'(found), 128'(1'b1));
    i_stall = 1'b1;
    i_redirect = 1'b1;
    i_redirectPc = 32'h0000_0200;
    step();
    i_stall = 1'b0;
    i_redirect = 1'b0;
    check("redir_stall_bubble", 128'(disp), 128'(0));
    check("redir_stall_req", 128'(o_imemReq), 128'(1'b1));
    check("redir_stall_addr", 128'(o_imemAddr), 128'(32'h0000_0200));
    lat_cfg = 2;
    step();
    check("redir_target_pc", 128'(o_pc), 128'(32'h0000_0200));

    // Asynchronous reset in the middle of a request
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (o_imemReq && !i_imemValid) found = 1'b1;
      else step();
    end
    check("midreq_seen", 128'(found), 128'(1'b1));
    rst = 1'b1;
    #1;
    check("async_rst_req", 128'(o_imemReq), 128'(1'b0));
    check("async_rst_addr", 128'(o_imemAddr), 128'(32'h0));
    check("async_rst_fields", 128'(disp), 128'(0));
    repeat (2) step();
    rst = 1'b0;
    exp_pc = 32'h0;

    // Randomized traffic: latency, stalls and redirects
    lat_cfg = -1;
    for (int k = 0; k < 2000; k++) begin
      i_stall = ($urandom_range(0, 99) < 25);
      i_redirect = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) i_redirectPc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else i_redirectPc = $urandom_range(0, 4095);
      step();
    end
    i_stall = 1'b0;
    i_redirect = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
